prbs_checker: RTL
=================

Name: prbs_checker

Overview:
- Receive-side companion to the PRBS-16 transmitter (x^16 + x^15 + 1); sits at the VLC receiver output, after bit recovery.
- Self-synchronises to the incoming PRBS stream and declares lock.
- Once locked, compares every received bit against a free-running local reference and counts bit errors and total bits for BER measurement.
- Detects loss of sync and re-hunts automatically.

Parameters:
- CNT_W, 32, width of the error and bit counters.
- LOCK_CNT, 32, consecutive matching bits required to declare lock (1..255).
- LOSS_WIN, 128, length of the loss-of-lock observation window in valid bits (2..65535).
- LOSS_THR, 8, number of errors within one window that forces loss of lock (1..LOSS_WIN).

Ports:
- clk, input, 1, single system clock; all logic on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- din, input, 1, received bit.
- din_valid, input, 1, din qualifier. Only cycles with din_valid=1 advance any state, window or counter.
- clear, input, 1, synchronous clear of err_cnt, bit_cnt and cnt_sat. Lock state is unaffected.
- locked, output, 1, high while in LOCKED.
- err_pulse, output, 1, one-cycle pulse per counted bit error.
- err_cnt, output, CNT_W, saturating count of errored bits while locked.
- bit_cnt, output, CNT_W, saturating count of bits checked while locked.
- cnt_sat, output, 1, sticky flag set when either counter saturates.

Behaviour:
- Reset (rst=0, async): state=FILL, 16-bit history h=0, all counters 0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0, cnt_sat=0.
- Prediction: h[0] is the most recent bit. Predicted bit p = h[14] ^ h[15], matching the transmitter recurrence s[n] = s[n-15] ^ s[n-16]. One comparison per valid bit.
- FILL:
  - Each valid bit shifts din into h (h[0]<=din, h[k]<=h[k-1]).
  - After 16 valid bits, go to VERIFY with the match counter cleared.
- VERIFY:
  - h is still fed with din.
  - If din==p and h is non-zero, increment the match counter. Otherwise clear the match counter.
  - An all-zero h never matches; this blocks lock-up on a dead or zero link.
  - When the match counter reaches LOCK_CNT, go to LOCKED.
  - Errors are not counted in this state.
- LOCKED:
  - h is fed with p, not din: free-running reference, so each channel error is counted exactly once.
  - Each valid bit: bit_cnt+1. If din!=p, also err_cnt+1 and err_pulse=1 on the following cycle.
  - Registered outputs update on the same clk edge that samples the bit.
  - locked=1 from the edge that enters LOCKED until the edge that leaves it.
- Loss of lock (LOCKED only):
  - A window counter counts valid bits, 0..LOSS_WIN-1, with an error tally alongside.
  - If the tally reaches LOSS_THR within a window, go to FILL on that edge. h, window and tally are cleared; that bit is still counted.
  - At window wrap, the tally resets to 0.
- Counters: saturate at 2^CNT_W-1 and never wrap. Any increment attempted at saturation sets cnt_sat.
- clear: zeroes err_cnt, bit_cnt and cnt_sat. clear has priority over a simultaneous increment, so that bit is not counted. No effect on the FSM, h, window or locked.
- din_valid=0: everything holds; err_pulse=0.
- rst asserted mid-operation: immediate return to reset values, regardless of state.

Test Plan:
1. Drive din from the transmitter (seed all-ones, din_valid=1 every cycle, defaults) -> locked rises after valid bit 48 (16 fill + 32 match). Then 10000 bits -> bit_cnt=10000, err_cnt=0, err_pulse never high.
2. While locked, invert one bit -> exactly one err_pulse, err_cnt=1 (not 3), locked stays 1, bit_cnt keeps incrementing.
3. Invert 8 bits within 128 -> locked falls on the 8th error edge, err_cnt=8. With clean data afterwards, relock after 48 further valid bits; counters continue from their held values.
4. din=0 constant for 1000 bits, then din=1 constant -> locked never asserts, err_cnt=0, bit_cnt=0.
5. CNT_W=4, locked, continuous errors with LOSS_THR=LOSS_WIN -> err_cnt sticks at 15 and cnt_sat=1. Assert clear on a cycle with an error -> err_cnt=0, bit_cnt=0, cnt_sat=0 next cycle, locked unchanged.
6. Toggle din_valid randomly at 50% -> same lock point and counts as test 1, measured in valid bits. Assert rst low mid-LOCKED -> outputs zero immediately; on release the block re-locks after 48 valid bits.

Source files
------------

// File: rtl/prbs_checker.sv
// PRBS-16 (x^16 + x^15 + 1) receive checker: self-synchronising hunt, lock detection,
// free-running reference comparison with saturating BER counters and loss-of-lock re-hunt.
`timescale 1ns/1ps
module prbs_checker #(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned LOCK_CNT = 32,
   parameter int unsigned LOSS_WIN = 128,
   parameter int unsigned LOSS_THR = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             cnt_sat
);

   localparam int unsigned FILL_W  = 4;
   localparam int unsigned MATCH_W = 8;
   localparam int unsigned WIN_W   = $clog2(LOSS_WIN);
   localparam int unsigned TAL_W   = $clog2(LOSS_THR + 1);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t             r_state,   w_state_nxt;
   logic [15:0]        r_h,       w_h_nxt;
   logic [FILL_W-1:0]  r_fill,    w_fill_nxt;
   logic [MATCH_W-1:0] r_match,   w_match_nxt;
   logic [WIN_W-1:0]   r_win,     w_win_nxt;
   logic [TAL_W-1:0]   r_tally,   w_tally_nxt;
   logic [CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
   logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
   logic               r_sat,     w_sat_nxt;
   logic               r_pulse,   w_pulse_nxt;
   logic               r_locked,  w_locked_nxt;
   logic               w_pred;
   logic               w_mis;
   logic               w_hit;
   logic               w_inc_bit;
   logic               w_inc_err;

   assign w_pred = r_h[14] ^ r_h[15];
   assign w_mis  = din ^ w_pred;
   // an all-zero history predicts zero forever, so it must never count as a match
   assign w_hit  = !w_mis && (r_h != 16'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_FILL;
         r_h       <= '0;
         r_fill    <= '0;
         r_match   <= '0;
         r_win     <= '0;
         r_tally   <= '0;
         r_err_cnt <= '0;
         r_bit_cnt <= '0;
         r_sat     <= 1'b0;
         r_pulse   <= 1'b0;
         r_locked  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_h       <= w_h_nxt;
         r_fill    <= w_fill_nxt;
         r_match   <= w_match_nxt;
         r_win     <= w_win_nxt;
         r_tally   <= w_tally_nxt;
         r_err_cnt <= w_err_cnt_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_sat     <= w_sat_nxt;
         r_pulse   <= w_pulse_nxt;
         r_locked  <= w_locked_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_h_nxt       = r_h;
      w_fill_nxt    = r_fill;
      w_match_nxt   = r_match;
      w_win_nxt     = r_win;
      w_tally_nxt   = r_tally;
      w_err_cnt_nxt = r_err_cnt;
      w_bit_cnt_nxt = r_bit_cnt;
      w_sat_nxt     = r_sat;
      w_pulse_nxt   = 1'b0;
      w_inc_bit     = 1'b0;
      w_inc_err     = 1'b0;

      if (din_valid) begin
         case (r_state)
            S_FILL: begin
               w_h_nxt = {r_h[14:0], din};
               if (r_fill == FILL_W'(15)) begin
                  w_state_nxt = S_VERIFY;
                  w_fill_nxt  = '0;
                  w_match_nxt = '0;
               end else begin
                  w_fill_nxt = r_fill + FILL_W'(1);
               end
            end
            S_VERIFY: begin
               w_h_nxt     = {r_h[14:0], din};
               w_match_nxt = w_hit ? r_match + MATCH_W'(1) : '0;
               if (w_hit && (r_match == MATCH_W'(LOCK_CNT - 1))) begin
                  w_state_nxt = S_LOCKED;
                  w_match_nxt = '0;
                  w_win_nxt   = '0;
                  w_tally_nxt = '0;
               end
            end
            S_LOCKED: begin
               // reference free-runs on its own prediction so one channel error counts once
               w_h_nxt   = {r_h[14:0], w_pred};
               w_inc_bit = 1'b1;
               w_inc_err = w_mis;
               if (w_mis && (r_tally == TAL_W'(LOSS_THR - 1))) begin
                  w_state_nxt = S_FILL;
                  w_h_nxt     = '0;
                  w_fill_nxt  = '0;
                  w_win_nxt   = '0;
                  w_tally_nxt = '0;
               end else if (r_win == WIN_W'(LOSS_WIN - 1)) begin
                  w_win_nxt   = '0;
                  w_tally_nxt = '0;
               end else begin
                  w_win_nxt   = r_win + WIN_W'(1);
                  w_tally_nxt = r_tally + TAL_W'(w_mis);
               end
            end
            default: begin
               w_state_nxt = S_FILL;
               w_h_nxt     = '0;
               w_fill_nxt  = '0;
            end
         endcase
      end

      if (clear) begin
         w_err_cnt_nxt = '0;
         w_bit_cnt_nxt = '0;
         w_sat_nxt     = 1'b0;
      end else begin
         if (w_inc_bit) begin
            if (r_bit_cnt == '1) w_sat_nxt = 1'b1;
            else                 w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
         end
         if (w_inc_err) begin
            w_pulse_nxt = 1'b1;
            if (r_err_cnt == '1) w_sat_nxt = 1'b1;
            else                 w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
         end
      end

      w_locked_nxt = (w_state_nxt == S_LOCKED);
   end

   assign locked    = r_locked;
   assign err_pulse = r_pulse;
   assign err_cnt   = r_err_cnt;
   assign bit_cnt   = r_bit_cnt;
   assign cnt_sat   = r_sat;

endmodule
